// File: rtl/cmd_frame_decoder.sv
// rtl/cmd_frame_decoder.sv - frame to address/data decoder with command FIFO
// Holds one command in the output register plus up to DEPTH more in a FIFO behind it.
module cmd_frame_decoder #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 4,
  parameter int ADDR_MSB = 1,
  parameter int ADDR_MAX = 2**ADDR_W-1,
  localparam int FRAME_W = ADDR_W+DATA_W,
  localparam int LVL_W   = $clog2(DEPTH+2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame,
  input  logic               frame_valid,
  input  logic               ack,
  input  logic               clr_ovf,
  output logic [ADDR_W-1:0]  address,
  output logic [DATA_W-1:0]  data,
  output logic               valid,
  output logic [LVL_W-1:0]   level,
  output logic               overflow,
  output logic               addr_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [ADDR_W:0] L_ADDR_MAX = (ADDR_W+1)'(ADDR_MAX);

  typedef enum logic {ST_EMPTY, ST_HOLD} state_t;
  state_t r_state, w_state_next;

  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;
  logic [FRAME_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]  r_address;
  logic [DATA_W-1:0]  r_data;
  logic [LVL_W-1:0]   r_level;
  logic               r_overflow, r_addr_err;
  logic               w_addr_ok, w_legal, w_pop, w_full, w_accept, w_drop;
  logic               w_load_frame, w_load_fifo, w_push;
  logic [FRAME_W-1:0] w_head;

  generate
    if (ADDR_MSB != 0) begin : g_addr_hi
      assign w_addr = frame[FRAME_W-1 -: ADDR_W];
      assign w_data = frame[DATA_W-1:0];
    end else begin : g_addr_lo
      assign w_addr = frame[ADDR_W-1:0];
      assign w_data = frame[FRAME_W-1 -: DATA_W];
    end
  endgenerate

  // Address legality is judged before capacity, so a rejected frame never counts as overflow.
  assign w_addr_ok = {1'b0, w_addr} <= L_ADDR_MAX;
  assign w_legal   = frame_valid & w_addr_ok;
  assign w_pop     = (r_state == ST_HOLD) & ack;
  assign w_full    = (r_state == ST_HOLD) & (r_count == CNT_W'(DEPTH));
  assign w_accept  = w_legal & (~w_full | w_pop);
  assign w_drop    = w_legal & w_full & ~w_pop;
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load_frame = 1'b0;
    w_load_fifo  = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_frame = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_pop) begin
          if (r_count != '0) begin
            w_load_fifo = 1'b1;
            w_push      = w_accept;
          end else if (w_accept) begin
            w_load_frame = 1'b1;
          end else begin
            w_state_next = ST_EMPTY;
          end
        end else begin
          w_push = w_accept;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // Storage array carries no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_addr, w_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_address  <= '0;
      r_data     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_push)      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_load_fifo) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_load_fifo)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_load_fifo) r_count <= r_count - CNT_W'(1);
      if (w_load_frame) begin
        r_address <= w_addr;
        r_data    <= w_data;
      end else if (w_load_fifo) begin
        {r_address, r_data} <= w_head;
      end
      if (w_accept && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_accept && w_pop) r_level <= r_level - LVL_W'(1);
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
      r_addr_err <= frame_valid & ~w_addr_ok;
    end
  end

  assign address  = r_address;
  assign data     = r_data;
  assign valid    = (r_state == ST_HOLD);
  assign level    = r_level;
  assign overflow = r_overflow;
  assign addr_err = r_addr_err;

endmodule
